tt_um_half_adder: RTL and testbench

Single-bit half adder with a combinational result path and a clocked, registered shadow of the result plus a carry-event statistics counter. The combinational path (sum, carry) must work with the clock idle and reset never applied. The registered path feeds downstream synchronous logic and on-chip debug readout in the Tiny Tapeout user area.

---
 rtl/tt_half_adder_pkg.sv | 28 ++
 rtl/sat_counter.sv | 57 +++++
 rtl/tt_um_half_adder.sv | 99 +++++++++
 tb/tb_tt_um_half_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_half_adder_pkg.sv
// -----------------------------------------------------------------------------
// tt_half_adder_pkg
//
// Shared definitions for the half-adder slice.
//   CNT_W_DEFAULT : default width of the carry-event counter
//   half_add()    : single-bit half adder, returns the packed {carry, sum}
//
// The adder is a function so the top level and any future users compute the
// result with exactly the same expression.
// -----------------------------------------------------------------------------
package tt_half_adder_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // Result bit positions inside the packed value returned by half_add()
  localparam int HA_SUM_BIT   = 0;
  localparam int HA_CARRY_BIT = 1;

  // Pure combinational half adder: bit 1 is the carry, bit 0 is the sum
  function automatic logic [1:0] half_add(input logic a, input logic b);
    logic [1:0] res;
    res               = '0;
    res[HA_SUM_BIT]   = a ^ b;
    res[HA_CARRY_BIT] = a & b;
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter with a clock enable and synchronous active-low reset.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset, wins over ena
//   ena    in   1 = the counter may change at this edge
//   inc    in   1 = count this enabled edge
//   count  out  current count (W bits), sticks at all-ones
//   sat    out  high while count is all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         sat_w;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Saturation is decoded straight from the register so it can never disagree
  // with the count value that is visible on the output.
  assign sat_w = (count_q == {W{1'b1}});

  // Next-count logic: step by one on an enabled, counted edge, but stop at
  // all-ones instead of wrapping back to zero.
  always_comb begin
    count_d = count_q;
    if (ena && inc && !sat_w) begin
      count_d = count_q + ONE;
    end
  end

  // Counter register; reset is sampled on every rising edge whether or not
  // the enable is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_w;

endmodule

// File: rtl/tt_um_half_adder.sv
// -----------------------------------------------------------------------------
// tt_um_half_adder
//
// Single-bit half adder with a purely combinational result and a registered
// shadow copy plus a saturating count of sampled carry events.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (priority over ena)
//   ena        in   clock enable for every register; 1 = update
//   a, b       in   addend bits
//   sum        out  a ^ b, combinational, independent of clock/reset
//   carry      out  a & b, combinational, independent of clock/reset
//   sum_q      out  sum sampled at the last enabled edge
//   carry_q    out  carry sampled at the last enabled edge
//   valid_q    out  high once sum_q/carry_q hold a sample taken after reset
//   carry_cnt  out  saturating count of enabled edges that sampled carry = 1
//   cnt_sat    out  high while carry_cnt is all-ones
// -----------------------------------------------------------------------------
module tt_um_half_adder
  import tt_half_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             a,
  input  logic             b,
  output logic             sum,
  output logic             carry,
  output logic             sum_q,
  output logic             carry_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             cnt_sat
);

  logic [1:0] ha_res;

  logic sum_reg_q;
  logic sum_reg_d;
  logic carry_reg_q;
  logic carry_reg_d;
  logic valid_reg_q;
  logic valid_reg_d;

  // The combinational result must work with the clock stopped and reset never
  // applied, so it is taken straight from the inputs with no register in the
  // path.
  assign ha_res = half_add(a, b);
  assign sum    = ha_res[HA_SUM_BIT];
  assign carry  = ha_res[HA_CARRY_BIT];

  // Next-state for the result shadow: capture the live result on an enabled
  // edge, otherwise hold everything including the valid flag.
  always_comb begin
    sum_reg_d   = sum_reg_q;
    carry_reg_d = carry_reg_q;
    valid_reg_d = valid_reg_q;
    if (ena) begin
      sum_reg_d   = sum;
      carry_reg_d = carry;
      valid_reg_d = 1'b1;
    end
  end

  // Result shadow registers; reset clears them even when ena is low so that
  // valid_q drops at the reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_reg_q   <= 1'b0;
      carry_reg_q <= 1'b0;
      valid_reg_q <= 1'b0;
    end else begin
      sum_reg_q   <= sum_reg_d;
      carry_reg_q <= carry_reg_d;
      valid_reg_q <= valid_reg_d;
    end
  end

  assign sum_q   = sum_reg_q;
  assign carry_q = carry_reg_q;
  assign valid_q = valid_reg_q;

  // Carry-event statistics: every enabled edge is a sample, and samples with
  // a carry are counted until the counter pins at all-ones.
  sat_counter #(
    .W (CNT_W)
  ) u_carry_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .inc   (carry),
    .count (carry_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_tt_um_half_adder.sv
// -----------------------------------------------------------------------------
// tb_tt_um_half_adder
//
// Two instances share the same stimulus: the default 8-bit counter and a
// 4-bit counter that saturates quickly. Directed vectors come from a table of
// hand-computed records; saturation, reset-while-disabled and a random run
// are written out as separate sequences.
// -----------------------------------------------------------------------------
module tb_tt_um_half_adder;

  logic clk;
  logic clk_run;
  logic rst_n;
  logic ena;
  logic a;
  logic b;

  logic       sum8, carry8, sum_q8, carry_q8, valid_q8, cnt_sat8;
  logic [7:0] carry_cnt8;
  logic       sum4, carry4, sum_q4, carry_q4, valid_q4, cnt_sat4;
  logic [3:0] carry_cnt4;

  int n_compared;
  int n_mismatched;

  // Expected register state, tracked from the behaviour description
  logic e_sum_q;
  logic e_carry_q;
  logic e_valid_q;
  int   n_carry_samples;

  typedef struct {
    logic rst_n;
    logic ena;
    logic a;
    logic b;
    logic e_sum_q;
    logic e_carry_q;
    logic e_valid_q;
    int   e_cnt;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic e_sum;
    logic e_carry;
  } comb_vec_t;

  vec_t      tbl[15];
  comb_vec_t comb_tbl[4];

  tt_um_half_adder dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .a         (a),
    .b         (b),
    .sum       (sum8),
    .carry     (carry8),
    .sum_q     (sum_q8),
    .carry_q   (carry_q8),
    .valid_q   (valid_q8),
    .carry_cnt (carry_cnt8),
    .cnt_sat   (cnt_sat8)
  );

  tt_um_half_adder #(
    .CNT_W (4)
  ) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .a         (a),
    .b         (b),
    .sum       (sum4),
    .carry     (carry4),
    .sum_q     (sum_q4),
    .carry_q   (carry_q4),
    .valid_q   (valid_q4),
    .carry_cnt (carry_cnt4),
    .cnt_sat   (cnt_sat4)
  );

  // Clock only toggles once clk_run is set, so the first test sees an idle clock
  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic ia, input logic ib);
    rst_n = r;
    ena   = e;
    a     = ia;
    b     = ib;
  endtask

  task automatic tickEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkComb(input logic e_sum, input logic e_carry);
    checkOutput("sum8",   {31'd0, sum8},   {31'd0, e_sum});
    checkOutput("carry8", {31'd0, carry8}, {31'd0, e_carry});
    checkOutput("sum4",   {31'd0, sum4},   {31'd0, e_sum});
    checkOutput("carry4", {31'd0, carry4}, {31'd0, e_carry});
  endtask

  // Compares both instances against the given register expectations
  task automatic checkRegs(input logic es, input logic ec, input logic ev, input int ecnt);
    int c8;
    int c4;
    c8 = (ecnt > 255) ? 255 : ecnt;
    c4 = (ecnt > 15) ? 15 : ecnt;
    checkOutput("sum_q8",     {31'd0, sum_q8},    {31'd0, es});
    checkOutput("carry_q8",   {31'd0, carry_q8},  {31'd0, ec});
    checkOutput("valid_q8",   {31'd0, valid_q8},  {31'd0, ev});
    checkOutput("carry_cnt8", {24'd0, carry_cnt8}, c8);
    checkOutput("cnt_sat8",   {31'd0, cnt_sat8},  (c8 == 255) ? 32'd1 : 32'd0);
    checkOutput("sum_q4",     {31'd0, sum_q4},    {31'd0, es});
    checkOutput("carry_q4",   {31'd0, carry_q4},  {31'd0, ec});
    checkOutput("valid_q4",   {31'd0, valid_q4},  {31'd0, ev});
    checkOutput("carry_cnt4", {28'd0, carry_cnt4}, c4);
    checkOutput("cnt_sat4",   {31'd0, cnt_sat4},  (c4 == 15) ? 32'd1 : 32'd0);
  endtask

  // One clocked step of the expected register behaviour, then a comparison
  task automatic stepAndCheck(input logic r, input logic e, input logic ia, input logic ib);
    applyStimulus(r, e, ia, ib);
    tickEdge();
    if (!r) begin
      e_sum_q         = 1'b0;
      e_carry_q       = 1'b0;
      e_valid_q       = 1'b0;
      n_carry_samples = 0;
    end else if (e) begin
      e_sum_q   = ia ^ ib;
      e_carry_q = ia & ib;
      e_valid_q = 1'b1;
      if (ia && ib) n_carry_samples++;
    end
    checkRegs(e_sum_q, e_carry_q, e_valid_q, n_carry_samples);
  endtask

  initial begin
    n_compared      = 0;
    n_mismatched    = 0;
    clk_run         = 1'b0;
    e_sum_q         = 1'b0;
    e_carry_q       = 1'b0;
    e_valid_q       = 1'b0;
    n_carry_samples = 0;

    comb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    comb_tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    comb_tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    comb_tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

    //              rst   ena   a     b     sum_q carry valid cnt
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};

    // Combinational path with the clock idle and reset never applied
    $display("[TB] combinational path, clock idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = comb_tbl[i].a;
      b = comb_tbl[i].b;
      #10;
      checkComb(comb_tbl[i].e_sum, comb_tbl[i].e_carry);
    end

    // Directed reset / enable / hold vectors
    $display("[TB] directed vector table");
    clk_run = 1'b1;
    #2;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].rst_n, tbl[i].ena, tbl[i].a, tbl[i].b);
      tickEdge();
      checkComb(tbl[i].a ^ tbl[i].b, tbl[i].a & tbl[i].b);
      checkRegs(tbl[i].e_sum_q, tbl[i].e_carry_q, tbl[i].e_valid_q, tbl[i].e_cnt);
    end
    e_sum_q         = 1'b0;
    e_carry_q       = 1'b0;
    e_valid_q       = 1'b1;
    n_carry_samples = 0;

    // Saturation: 20 enabled carry samples, the 4-bit counter pins at 15
    $display("[TB] saturation run");
    for (int k = 1; k <= 20; k++) begin
      stepAndCheck(1'b1, 1'b1, 1'b1, 1'b1);
    end
    checkOutput("cnt4_pinned", {28'd0, carry_cnt4}, 32'd15);
    checkOutput("cnt8_at20",   {24'd0, carry_cnt8}, 32'd20);

    // Reset while disabled with the counter sitting at 7
    $display("[TB] reset with ena low");
    stepAndCheck(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      stepAndCheck(1'b1, 1'b1, 1'b1, 1'b1);
    end
    checkOutput("cnt8_at7", {24'd0, carry_cnt8}, 32'd7);
    stepAndCheck(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("valid_after_rst", {31'd0, valid_q8}, 32'd0);
    checkOutput("cnt_after_rst",   {24'd0, carry_cnt8}, 32'd0);

    // Random addends, mostly enabled, long enough to saturate the 4-bit counter
    $display("[TB] random run");
    for (int k = 0; k < 1000; k++) begin
      logic ra;
      logic rb;
      logic re;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 7) != 0);
      stepAndCheck(1'b1, re, ra, rb);
      checkComb(ra ^ rb, ra & rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
